fpu_host_sequencer: RTL
=======================

// Module: fpu_host_sequencer
// PURPOSE
// Bus initiator for the FPU register window. Host logic supplies two 32-bit
// operands and a 4-bit opcode in one request. The block runs the byte-wide
// write cycles, waits for cmd_end, and reads back the 32-bit result. It then
// acknowledges the FPU and returns the result with a done pulse. It sits
// between the CPU-side datapath and the fpu bus pins (addr/cs/rd/wr, active-low strobes).
// PARAMETERS
// STROBE_CYC   2        cycles rd/wr held low per access (>=1)
// RESULT_BASE  6'h09    address of result byte 0; bytes 1..3 at +1..+3
// TIMEOUT_CYC  1024     max cycles waiting for cmd_end before error abort
// PORTS
// clk          in   1   clock, all logic on rising edge
// arst         in   1   reset, synchronous, active-high
// req          in   1   start request, sampled only when ready=1
// op           in   4   opcode, written verbatim to addr 6'h08
// opa          in   32  operand A, written to addr 6'h00..6'h03 (LS byte first)
// opb          in   32  operand B, written to addr 6'h04..6'h07 (LS byte first)
// ready        out  1   idle and able to accept req
// done         out  1   one-cycle pulse, transaction finished
// err          out  1   valid with done: 1 = cmd_end timeout
// result       out  32  result word, held stable from done until next done
// addr         out  6   FPU register address
// bus_dout     out  8   write data to FPU databus_in
// bus_din      in   8   read data from FPU databus_out
// cs           out  1   chip select, active-low
// rd           out  1   read strobe, active-low
// wr           out  1   write strobe, active-low
// end_ack      out  1   acknowledge to FPU, active-high one-cycle pulse
// cmd_end      in   1   FPU end-of-command
// fpu_busy     in   1   FPU operation in progress
// BEHAVIOUR
// - Reset: state IDLE; ready=1, done=0, err=0, result=0, addr=0, bus_dout=0.
//   Also cs=rd=wr=1 and end_ack=0. Reset mid-transaction aborts with no done.
// - Strobes are registered outputs. rd and wr are never low together.
// - IDLE: ready = ~fpu_busy. On req&ready, latch op/opa/opb.
//   Clear idx (4-bit) and go to WR_SETUP.
// - Write access: WR_SETUP 1 cycle (addr,bus_dout valid, cs=0, wr=1).
//   Then WR_STROBE for STROBE_CYC cycles (wr=0).
//   Then WR_HOLD 1 cycle (wr=1, cs=1; addr/data unchanged).
//   idx 0..7 write operand bytes and idx 8 writes op. After idx 8, go to WAIT_END.
//   Total write phase = 9*(STROBE_CYC+2) cycles.
// - WAIT_END: clear the timeout counter on entry. On cmd_end=1, set idx=0 and go to RD_SETUP.
//   If the counter reaches TIMEOUT_CYC-1 without cmd_end, go to DONE with err=1.
//   result is unchanged on timeout. An unknown opcode ends in this timeout.
// - Read access: RD_SETUP 1 cycle (addr=RESULT_BASE+idx, cs=0, rd=1).
//   Then RD_STROBE for STROBE_CYC cycles (rd=0).
//   On the last strobe cycle, capture bus_din into result byte idx.
//   Then RD_HOLD 1 cycle (cs=rd=1). After idx 3, go to ACK.
//   result updates only at the end of a successful transaction: use a shadow register, copied on entry to DONE.
// - ACK: end_ack=1 for exactly 1 cycle. Then ACK_WAIT until cmd_end=0 (bounded by TIMEOUT_CYC, err=1 on expiry).
// - DONE: done=1 for 1 cycle, then IDLE. ready is 0 from req acceptance through DONE.
//   ready returns in the cycle after done.
// - req while ready=0 is ignored, not queued. cmd_end asserted before WAIT_END is ignored.
// TESTING
// - Reset: arst=1 two cycles -> cs=rd=wr=1, end_ack=0, ready=1, done=0, result=0.
// - Add: opa=32'h3F800000, opb=32'h40000000, op=4'h1, STROBE_CYC=2 -> write sequence:
//   addr 0..8 = 00,00,80,3F,00,00,00,40,01, each wr low 2 cycles.
//   Model raises cmd_end 5 cycles later with result bytes 00,00,40,40 at 09..0C
//   -> one end_ack pulse, done with err=0, result=32'h40400000.
// - Timeout: TIMEOUT_CYC=16, model never raises cmd_end -> done at 16 cycles into WAIT_END.
//   err=1, result keeps its previous value, no rd strobe and no end_ack issued.
// - Busy gating: fpu_busy=1 with req=1 -> ready=0, no cs activity.
//   Drop fpu_busy -> transaction starts the next cycle.
// - Reset mid-op: assert arst during the WR_STROBE of idx 4 -> next cycle wr=cs=1, ready=1, no done.
//   A fresh request then completes normally.
// - Back-to-back: req held high through done -> second transaction starts one cycle after done.
//   A req pulsed during WAIT_END is ignored.

Source files
------------

// File: rtl/fpu_host_sequencer.sv
// Drives the FPU register window: byte-wide operand/opcode writes, wait for cmd_end, 4-byte result read, end_ack.
// Bus strobes are registered; result is published from a shadow register only when a transaction succeeds.
`timescale 1ns/1ps
module fpu_host_sequencer #(
  parameter int unsigned STROBE_CYC  = 2,
  parameter logic [5:0]  RESULT_BASE = 6'h09,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        req_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] result_o,
  output logic [5:0]  addr_o,
  output logic [7:0]  bus_dout_o,
  input  logic [7:0]  bus_din_i,
  output logic        cs_o,
  output logic        rd_o,
  output logic        wr_o,
  output logic        end_ack_o,
  input  logic        cmd_end_i,
  input  logic        fpu_busy_i
);

  localparam int SCW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [SCW-1:0] STRB_LAST = SCW'(STROBE_CYC - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYC - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_SETUP  = 4'd1;
  localparam logic [3:0] S_WR_STROBE = 4'd2;
  localparam logic [3:0] S_WR_HOLD   = 4'd3;
  localparam logic [3:0] S_WAIT_END  = 4'd4;
  localparam logic [3:0] S_RD_SETUP  = 4'd5;
  localparam logic [3:0] S_RD_STROBE = 4'd6;
  localparam logic [3:0] S_RD_HOLD   = 4'd7;
  localparam logic [3:0] S_ACK       = 4'd8;
  localparam logic [3:0] S_ACK_WAIT  = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  logic [3:0]     state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [SCW-1:0] strb_q, strb_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [3:0]     op_q, op_d;
  logic [31:0]    opa_q, opa_d;
  logic [31:0]    opb_q, opb_d;
  logic [31:0]    shadow_q, shadow_d;
  logic [31:0]    result_q, result_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic [5:0]     addr_q, addr_d;
  logic [7:0]     dout_q, dout_d;
  logic           cs_q, cs_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic           ack_q, ack_d;
  logic [7:0]     wr_byte;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    strb_d   = strb_q;
    tmo_d    = tmo_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    shadow_d = shadow_q;
    result_d = result_q;
    err_d    = err_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    wr_byte  = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (req_i && !fpu_busy_i) begin
          op_d    = op_i;
          opa_d   = opa_i;
          opb_d   = opb_i;
          idx_d   = 4'd0;
          state_d = S_WR_SETUP;
        end
      end
      S_WR_SETUP: begin
        strb_d  = '0;
        state_d = S_WR_STROBE;
      end
      S_WR_STROBE: begin
        if (strb_q == STRB_LAST) state_d = S_WR_HOLD;
        else                     strb_d  = strb_q + 1'b1;
      end
      S_WR_HOLD: begin
        if (idx_q == 4'd8) begin
          tmo_d   = '0;
          state_d = S_WAIT_END;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_WR_SETUP;
        end
      end
      S_WAIT_END: begin
        // cmd_end wins over an expiring counter in the same cycle
        if (cmd_end_i) begin
          idx_d   = 4'd0;
          state_d = S_RD_SETUP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RD_SETUP: begin
        strb_d  = '0;
        state_d = S_RD_STROBE;
      end
      S_RD_STROBE: begin
        if (strb_q == STRB_LAST) begin
          shadow_d[{idx_q[1:0], 3'b000} +: 8] = bus_din_i;
          state_d = S_RD_HOLD;
        end else begin
          strb_d = strb_q + 1'b1;
        end
      end
      S_RD_HOLD: begin
        if (idx_q == 4'd3) begin
          state_d = S_ACK;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_RD_SETUP;
        end
      end
      S_ACK: begin
        tmo_d   = '0;
        state_d = S_ACK_WAIT;
      end
      S_ACK_WAIT: begin
        if (!cmd_end_i) begin
          err_d    = 1'b0;
          result_d = shadow_q;
          state_d  = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the pins change with the state register
    if (idx_d < 4'd4)      wr_byte = opa_d[{idx_d[1:0], 3'b000} +: 8];
    else if (idx_d < 4'd8) wr_byte = opb_d[{idx_d[1:0], 3'b000} +: 8];
    else                   wr_byte = {4'h0, op_d};

    if (state_d == S_WR_SETUP) begin
      addr_d = {2'b00, idx_d};
      dout_d = wr_byte;
    end
    if (state_d == S_RD_SETUP) addr_d = RESULT_BASE + {2'b00, idx_d};

    cs_d   = !((state_d == S_WR_SETUP) || (state_d == S_WR_STROBE) ||
               (state_d == S_RD_SETUP) || (state_d == S_RD_STROBE));
    wr_d   = (state_d != S_WR_STROBE);
    rd_d   = (state_d != S_RD_STROBE);
    ack_d  = (state_d == S_ACK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      strb_q   <= '0;
      tmo_q    <= '0;
      op_q     <= 4'h0;
      opa_q    <= 32'h0;
      opb_q    <= 32'h0;
      shadow_q <= 32'h0;
      result_q <= 32'h0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= 6'h00;
      dout_q   <= 8'h00;
      cs_q     <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      strb_q   <= strb_d;
      tmo_q    <= tmo_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      err_q    <= err_d;
      done_q   <= done_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack_q    <= ack_d;
    end
  end

  assign ready_o    = (state_q == S_IDLE) && !fpu_busy_i;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign result_o   = result_q;
  assign addr_o     = addr_q;
  assign bus_dout_o = dout_q;
  assign cs_o       = cs_q;
  assign rd_o       = rd_q;
  assign wr_o       = wr_q;
  assign end_ack_o  = ack_q;

endmodule
